mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the instruction-fetch stage (read-only) and the data-memory stage (read/write) of the 5-stage pipeline.
- Sequences each access over a req/ack handshake with variable latency.
- Returns read data to the winning requester.
- Drives the stall signals that freeze PC/IFID or the later pipeline registers while a requester waits.

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Optional watchdog: define MEM_ARB_WATCHDOG_EN to enable the BUSY timeout and arb_err.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              arb_err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 8-bit watchdog counter");
  end

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_t;

  state_t            state, state_d;
  logic              last_dm, last_dm_d;
  logic              mem_req_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_d, dm_rdata_d;
  logic              if_valid_d, dm_valid_d;
  logic              wd_fire;
  logic [DATA_W-1:0] resp_data;

  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_req & ~dm_valid;

`ifdef MEM_ARB_WATCHDOG_EN
  localparam logic [DATA_W-1:0] WD_DATA = DATA_W'(32'hDEAD_BEEF);

  logic [7:0] wd_cnt;
  logic       arb_err_q;
  logic       busy;
  logic       grant;

  assign busy      = (state == BUSY_IF) || (state == BUSY_DM);
  assign grant     = (state == IDLE) && (state_d != IDLE);
  assign wd_fire   = busy && !mem_ack && (({1'b0, wd_cnt} + 9'd1) >= 9'(TIMEOUT_CYCLES));
  assign resp_data = wd_fire ? WD_DATA : mem_rdata;
  assign arb_err   = arb_err_q;

  // watchdog: counts BUSY cycles without an ack, error is sticky until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt    <= 8'd0;
      arb_err_q <= 1'b0;
    end else begin
      if (grant) begin
        wd_cnt <= 8'd0;
      end else if (busy && !mem_ack) begin
        wd_cnt <= wd_cnt + 8'd1;
      end
      if (wd_fire) begin
        arb_err_q <= 1'b1;
      end
    end
  end
`else
  assign wd_fire   = 1'b0;
  assign resp_data = mem_rdata;
  assign arb_err   = 1'b0;
`endif

  always_comb begin
    state_d     = state;
    last_dm_d   = last_dm;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_rdata_d  = if_rdata;
    dm_rdata_d  = dm_rdata;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    case (state)
      IDLE: begin
        // data wins ties unless it also won the previous grant
        if (dm_req && (!if_req || !last_dm)) begin
          state_d     = BUSY_DM;
          last_dm_d   = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
        end else if (if_req) begin
          state_d    = BUSY_IF;
          last_dm_d  = 1'b0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
        end
      end
      BUSY_IF: begin
        if (mem_ack || wd_fire) begin
          if_rdata_d = resp_data;
          if_valid_d = 1'b1;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          state_d    = RESP;
        end
      end
      BUSY_DM: begin
        if (mem_ack || wd_fire) begin
          // a completed store leaves the load-data register untouched
          if (wd_fire || !mem_we) begin
            dm_rdata_d = resp_data;
          end
          dm_valid_d = 1'b1;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          state_d    = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_dm   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
    end else begin
      state     <= state_d;
      last_dm   <= last_dm_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if_rdata  <= if_rdata_d;
      dm_rdata  <= dm_rdata_d;
      if_valid  <= if_valid_d;
      dm_valid  <= dm_valid_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
// Watchdog scenario runs when MEM_ARB_WATCHDOG_EN is defined.
module tb_mem_port_arbiter;
`ifdef MEM_ARB_WATCHDOG_EN
  localparam int TMO = 10;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic [31:0] if_rdata;
  logic        if_valid, if_stall;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = 32'h0;
  logic [31:0] dm_wdata = 32'h0;
  logic [31:0] dm_rdata;
  logic        dm_valid, dm_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic        arb_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .arb_err(arb_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // memory: auto-ack after ack_delay cycles, or manual acks via inject_ack
  bit          auto_ack = 1'b1;
  int          ack_delay = 0;
  int          rcnt = 0;
  bit          inject_ack = 1'b0;
  logic [31:0] mem_arr [logic [31:0]];

  always @(posedge clk) begin
    #1;
    if (!auto_ack) begin
      mem_ack   = inject_ack;
      mem_rdata = 32'h0BAD_0ACE;
      rcnt      = 0;
    end else if (mem_req && !mem_ack) begin
      if (rcnt == ack_delay) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          mem_arr[mem_addr] = mem_wdata;
          mem_rdata = 32'h0;
        end else begin
          mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : (mem_addr ^ 32'h5A5A_0000);
        end
        rcnt = 0;
      end else begin
        mem_ack = 1'b0;
        rcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      rcnt    = 0;
    end
  end

  // reference model: one outstanding transaction, a response cycle, then arbitration
  bit          cur_active = 0, cur_dm = 0, cur_we = 0, in_resp = 0, last_was_dm = 0;
  int          cur_waited = 0;
  logic        exp_mem_req = 0, exp_mem_we = 0, exp_if_valid = 0, exp_dm_valid = 0, exp_err = 0;
  logic [31:0] exp_mem_addr = 0, exp_mem_wdata = 0, exp_if_rdata = 0, exp_dm_rdata = 0;

  always @(posedge clk) begin : model
    bit          done, tmo;
    logic [31:0] d;
    if (rst) begin
      cur_active = 0; in_resp = 0; last_was_dm = 0; cur_waited = 0;
      exp_mem_req = 0; exp_mem_we = 0; exp_mem_addr = 0; exp_mem_wdata = 0;
      exp_if_rdata = 0; exp_dm_rdata = 0; exp_if_valid = 0; exp_dm_valid = 0; exp_err = 0;
    end else begin
      exp_if_valid = 0;
      exp_dm_valid = 0;
      if (in_resp) begin
        in_resp = 0;
      end else if (cur_active) begin
        done = 0; tmo = 0; d = mem_rdata;
        if (mem_ack) done = 1;
        else begin
          cur_waited++;
`ifdef MEM_ARB_WATCHDOG_EN
          if (cur_waited == TMO) begin
            done = 1; tmo = 1; d = 32'hDEAD_BEEF; exp_err = 1;
          end
`endif
        end
        if (done) begin
          if (cur_dm) begin
            exp_dm_valid = 1;
            if (!cur_we || tmo) exp_dm_rdata = d;
          end else begin
            exp_if_valid = 1;
            exp_if_rdata = d;
          end
          cur_active = 0; in_resp = 1; exp_mem_req = 0; exp_mem_we = 0;
        end
      end else if (dm_req && (!if_req || !last_was_dm)) begin
        cur_active = 1; cur_dm = 1; cur_we = dm_we; cur_waited = 0; last_was_dm = 1;
        exp_mem_req = 1; exp_mem_we = dm_we; exp_mem_addr = dm_addr; exp_mem_wdata = dm_wdata;
      end else if (if_req) begin
        cur_active = 1; cur_dm = 0; cur_we = 0; cur_waited = 0; last_was_dm = 0;
        exp_mem_req = 1; exp_mem_we = 0; exp_mem_addr = if_addr;
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("mem_req", 32'(mem_req), 32'(exp_mem_req));
      chk("mem_we", 32'(mem_we), 32'(exp_mem_we));
      chk("mem_addr", mem_addr, exp_mem_addr);
      chk("mem_wdata", mem_wdata, exp_mem_wdata);
      chk("if_valid", 32'(if_valid), 32'(exp_if_valid));
      chk("if_rdata", if_rdata, exp_if_rdata);
      chk("dm_valid", 32'(dm_valid), 32'(exp_dm_valid));
      chk("dm_rdata", dm_rdata, exp_dm_rdata);
      chk("if_stall", 32'(if_stall), 32'(if_req & ~exp_if_valid));
      chk("dm_stall", 32'(dm_stall), 32'(dm_req & ~exp_dm_valid));
      chk("arb_err", 32'(arb_err), 32'(exp_err));
    end
  end

  typedef struct packed {logic [31:0] addr; logic we; logic [31:0] wdata;} grant_t;
  grant_t gq[$];
  logic   prev_req = 1'b0;
  int     ifv_cnt = 0, dmv_cnt = 0;

  always @(negedge clk) begin
    if (mem_req && !prev_req) gq.push_back('{addr: mem_addr, we: mem_we, wdata: mem_wdata});
    prev_req = mem_req;
    if (if_valid) ifv_cnt++;
    if (dm_valid) dmv_cnt++;
  end

  task automatic wait_valid(input bit dm, input int maxc, output int n);
    bit seen;
    n = -1;
    seen = 0;
    for (int i = 1; i <= maxc && !seen; i++) begin
      @(negedge clk);
      if (dm ? dm_valid : if_valid) begin
        n = i;
        seen = 1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "time budget exceeded");
  end

  initial begin
    int n, v0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_dm_valid", 32'(dm_valid), 32'h0);

    // single fetch, ack three cycles after mem_req
    mem_arr[32'h40] = 32'h8C22_0004;
    ack_delay = 3;
    gq.delete();
    @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h40;
    wait_valid(1'b0, 20, n);
    chk("fetch_latency", n, 6);
    chk("fetch_rdata", if_rdata, 32'h8C22_0004);
    chk("fetch_stall_at_valid", 32'(if_stall), 32'h0);
    @(posedge clk); #1 if_req = 1'b0;
    repeat (3) @(posedge clk);
    chk("fetch_pulses", ifv_cnt, 1);
    chk("fetch_grants", gq.size(), 1);
    if (gq.size() >= 1) begin
      chk("fetch_addr", gq[0].addr, 32'h40);
      chk("fetch_we", 32'(gq[0].we), 32'h0);
    end

    // both requesters together: DM, IF, DM, IF
    ack_delay = 0;
    gq.delete();
    @(posedge clk); #1
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    repeat (12) @(posedge clk);
    #1 if_req = 1'b0; dm_req = 1'b0;
    repeat (4) @(posedge clk);
    chk("alt_grants", gq.size(), 4);
    if (gq.size() >= 4) begin
      chk("alt_g0", gq[0].addr, 32'h200);
      chk("alt_g1", gq[1].addr, 32'h40);
      chk("alt_g2", gq[2].addr, 32'h200);
      chk("alt_g3", gq[3].addr, 32'h40);
    end

    // store then load of the same word
    ack_delay = 1;
    gq.delete();
    @(posedge clk); #1
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'h1234_5678;
    wait_valid(1'b1, 20, n);
    chk("store_latency", n, 4);
    chk("store_rdata_kept", dm_rdata, 32'h5A5A_0200);
    @(posedge clk); #1 dm_we = 1'b0; dm_wdata = 32'h0;
    wait_valid(1'b1, 20, n);
    chk("load_latency", n, 4);
    chk("load_rdata", dm_rdata, 32'h1234_5678);
    @(posedge clk); #1 dm_req = 1'b0;
    chk("sl_grants", gq.size(), 2);
    if (gq.size() >= 2) begin
      chk("store_we", 32'(gq[0].we), 32'h1);
      chk("store_wdata", gq[0].wdata, 32'h1234_5678);
      chk("store_addr", gq[0].addr, 32'h100);
      chk("load_we", 32'(gq[1].we), 32'h0);
    end

    // reset while a load is in flight, then a late ack
    auto_ack = 1'b0;
    inject_ack = 1'b0;
    repeat (2) @(posedge clk);
    v0 = dmv_cnt;
    #1 dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; dm_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 inject_ack = 1'b1;
    @(posedge clk); #1 inject_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_mem_req", 32'(mem_req), 32'h0);
    chk("rstmid_no_valid", dmv_cnt - v0, 0);
    chk("rstmid_dm_rdata", dm_rdata, 32'h0);
    auto_ack = 1'b1;
    ack_delay = 0;
    gq.delete();
    @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h44;
    wait_valid(1'b0, 20, n);
    chk("post_rst_latency", n, 3);
    chk("post_rst_rdata", if_rdata, 32'h5A5A_0044);
    @(posedge clk); #1 if_req = 1'b0;
    chk("post_rst_grants", gq.size(), 1);

`ifdef MEM_ARB_WATCHDOG_EN
    auto_ack = 1'b0;
    inject_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 if_req = 1'b1; if_addr = 32'h80;
    wait_valid(1'b0, 30, n);
    chk("wd_latency", n, 12);
    chk("wd_rdata", if_rdata, 32'hDEAD_BEEF);
    chk("wd_err", 32'(arb_err), 32'h1);
    @(posedge clk); #1 if_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("wd_err_sticky", 32'(arb_err), 32'h1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("wd_err_cleared", 32'(arb_err), 32'h0);
`else
    chk("arb_err_off", 32'(arb_err), 32'h0);
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
